// File: rtl/latch_d_1b.sv
// Level-sensitive D latch with asynchronous active-low clear.
// It is transparent while enable is high and holds while enable is low.
module latch_d_1b (
   input  logic in,
   output logic out,
   input  logic enable,
   input  logic reset_n
);

   // The clear takes priority over the transparent phase.
   always_latch begin
      if (!reset_n) begin
         out <= 1'b0;
      end else if (enable) begin
         out <= in;
      end
   end

endmodule

// File: rtl/flipflop_d_rise_1bit.sv
// Rising-edge D flip-flop built as a master-slave pair of latches, with asynchronous active-low clear.
// The master is open while clock is low; the slave opens on the rising edge and passes the captured bit.
module flipflop_d_rise_1bit (
   input  logic in,
   output logic out,
   input  logic clock,
   input  logic reset_n
);

   logic clock_n;
   logic master_q;

   assign clock_n = ~clock;

   latch_d_1b u_master (
      .in      (in),
      .out     (master_q),
      .enable  (clock_n),
      .reset_n (reset_n)
   );

   latch_d_1b u_slave (
      .in      (master_q),
      .out     (out),
      .enable  (clock),
      .reset_n (reset_n)
   );

endmodule

// File: tb/tb_flipflop_d_rise_1bit.sv
// Bench for flipflop_d_rise_1bit: directed vector table, glitch sequences, and random traffic.
// The random traffic is checked against an event-level model of the stored bit.
module tb_flipflop_d_rise_1bit;

   logic data;
   logic q;
   logic clock;
   logic reset_n;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic  rn;
      logic  d;
      logic  clk;
      logic  exp;
      string name;
   } vec_t;

   vec_t vecs[$];

   flipflop_d_rise_1bit dut (
      .in      (data),
      .out     (q),
      .clock   (clock),
      .reset_n (reset_n)
   );

   task automatic check(input string name, input logic exp);
      total++;
      if (q !== exp) begin
         bad++;
         $display("FAIL %s: out=%b expected=%b at t=%0t", name, q, exp, $time);
      end
   endtask

   // Apply one step of inputs, wait 1 ns, then compare.
   task automatic step(input logic rn, input logic d, input logic clk,
                       input logic exp, input string name);
      reset_n = rn;
      data    = d;
      clock   = clk;
      #1;
      check(name, exp);
   endtask

   logic model;
   logic nd;

   initial begin
      data    = 1'b1;
      clock   = 1'b0;
      reset_n = 1'b0;

      // rn, in, clock, expected out, name
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, "rst_assert_idle"});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, "rst_release_no_edge"});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, "in0_while_low"});
      vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, "capture0_rise"});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, "fall_in1_holds0"});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, "capture1_rise"});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, "hold_fall"});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, "hold_rise"});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, "fall_in0_ignored"});
      vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, "capture0_rise2"});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, "fall_after0"});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, "in1_while_low"});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, "rise_to1"});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, "clear_clock_high"});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, "clear_release_high"});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, "fall_after_clear"});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, "rise_after_clear"});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, "fall_before_coincide"});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, "reset_with_rise"});
      vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, "release_low_no_edge"});
      vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, "rise_after_release"});

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rn, vecs[i].d, vecs[i].clk, vecs[i].exp, vecs[i].name);
      end

      // Glitches on in while clock is high: stored 1 must hold.
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'(i % 2 == 0 ? 0 : 1), 1'b1, 1'b1, "glitch_clock_high");
      end
      step(1'b1, 1'b0, 1'b1, 1'b1, "glitch_high_end0");
      // Glitches on in while clock is low: out still holds 1.
      step(1'b1, 1'b0, 1'b0, 1'b1, "fall_glitch_start");
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'(i % 2 == 0 ? 1 : 0), 1'b0, 1'b1, "glitch_clock_low");
      end
      step(1'b1, 1'b0, 1'b1, 1'b0, "rise_after_glitch");

      // Random traffic; in only changes away from the rising edge.
      model = 1'b0;
      step(1'b1, 1'b0, 1'b0, model, "rand_start");
      for (int cyc = 0; cyc < 400; cyc++) begin
         nd = 1'($urandom_range(0, 1));
         step(1'b1, nd, 1'b0, model, "rand_low_in");
         if ($urandom_range(0, 15) == 0) begin
            model = 1'b0;
            step(1'b0, data, 1'b0, model, "rand_clear");
            step(1'b1, data, 1'b0, model, "rand_clear_release");
         end
         model = data;
         step(1'b1, data, 1'b1, model, "rand_rise");
         nd = 1'($urandom_range(0, 1));
         step(1'b1, nd, 1'b1, model, "rand_high_in");
         step(1'b1, data, 1'b0, model, "rand_fall");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
